// File: rtl/parking_gate_arbiter_if.sv
// Gate-side signal bundle for the car-park control core: sensors and keypads in,
// LEDs and occupancy out.
interface parking_gate_arbiter_if;
  logic        sensor1_entry;
  logic        sensor2_entry;
  logic        sensor1_exit;
  logic        sensor2_exit;
  logic [15:0] password1;
  logic [15:0] password2;
  logic        pass_valid1;
  logic        pass_valid2;
  logic        Greenled1;
  logic        Greenled2;
  logic        Redled1;
  logic        Redled2;
  logic [3:0]  occupancy;
  logic        full;

  modport master (
    output sensor1_entry, sensor2_entry, sensor1_exit, sensor2_exit,
    output password1, password2, pass_valid1, pass_valid2,
    input  Greenled1, Greenled2, Redled1, Redled2, occupancy, full
  );

  modport slave (
    input  sensor1_entry, sensor2_entry, sensor1_exit, sensor2_exit,
    input  password1, password2, pass_valid1, pass_valid2,
    output Greenled1, Greenled2, Redled1, Redled2, occupancy, full
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Two-gate car-park core: per-gate password FSMs, round-robin slot arbitration
// and the shared occupancy counter.
module parking_gate_arbiter #(
  parameter int unsigned Capacity = 8,
  parameter logic [15:0] Password = 16'h1234,
  parameter int unsigned MaxTries = 3,
  parameter int unsigned Timeout  = 64
) (
  input logic                   clk,
  input logic                   rst,
  parking_gate_arbiter_if.slave bus
);

  localparam int unsigned TimerW = $clog2(Timeout + 1);
  localparam int unsigned TriesW = $clog2(MaxTries + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StFull,
    StOpen,
    StLock
  } gate_state_e;

  gate_state_e       state_q [2];
  gate_state_e       state_d [2];
  logic [TimerW-1:0] timer_q [2];
  logic [TimerW-1:0] timer_d [2];
  logic [TriesW-1:0] tries_q [2];
  logic [TriesW-1:0] tries_d [2];
  logic [1:0]        exit_q;
  logic              rr_q;
  logic              rr_d;
  logic [3:0]        occ_q;
  logic [3:0]        occ_d;

  logic [1:0]  entry;
  logic [1:0]  exit_lvl;
  logic [1:0]  exit_rise;
  logic [1:0]  pass_valid;
  logic [15:0] password [2];
  logic [1:0]  req;
  logic [1:0]  grant;
  logic [3:0]  free;
  int          occ_sum;

  assign entry       = {bus.sensor2_entry, bus.sensor1_entry};
  assign exit_lvl    = {bus.sensor2_exit, bus.sensor1_exit};
  assign pass_valid  = {bus.pass_valid2, bus.pass_valid1};
  assign password[0] = bus.password1;
  assign password[1] = bus.password2;

  assign exit_rise = exit_lvl & ~exit_q;
  assign free      = 4'(Capacity) - occ_q;
  assign req[0]    = (state_q[0] == StReq);
  assign req[1]    = (state_q[1] == StReq);

  // The last free slot goes to the pointer gate; the pointer only moves when it
  // actually settles a contention.
  always_comb begin
    grant = 2'b00;
    rr_d  = rr_q;
    unique case (req)
      2'b01: grant = (free != 4'd0) ? 2'b01 : 2'b00;
      2'b10: grant = (free != 4'd0) ? 2'b10 : 2'b00;
      2'b11: begin
        if (free >= 4'd2) begin
          grant = 2'b11;
        end else if (free == 4'd1) begin
          grant = rr_q ? 2'b10 : 2'b01;
          rr_d  = ~rr_q;
        end
      end
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      state_d[g] = state_q[g];
      timer_d[g] = timer_q[g];
      tries_d[g] = tries_q[g];
      unique case (state_q[g])
        StIdle: begin
          if (entry[g]) begin
            state_d[g] = StCheck;
            timer_d[g] = '0;
          end
        end
        StCheck: begin
          if (!entry[g]) begin
            state_d[g] = StIdle;
          end else if (pass_valid[g]) begin
            // Any strobe restarts the inactivity window; a correct code beats expiry.
            timer_d[g] = '0;
            if (password[g] == Password) begin
              state_d[g] = StReq;
              tries_d[g] = '0;
            end else begin
              tries_d[g] = tries_q[g] + 1'b1;
              if (tries_q[g] == TriesW'(MaxTries - 1)) begin
                state_d[g] = StLock;
              end
            end
          end else if (timer_q[g] == TimerW'(Timeout - 1)) begin
            state_d[g] = StIdle;
          end else begin
            timer_d[g] = timer_q[g] + 1'b1;
          end
        end
        // Without a grant here the park is full or this gate lost the last slot.
        StReq: state_d[g] = grant[g] ? StOpen : StFull;
        StFull: begin
          if (!entry[g]) begin
            state_d[g] = StIdle;
          end else if (occ_q < 4'(Capacity)) begin
            state_d[g] = StReq;
          end
        end
        StOpen: begin
          if (!entry[g]) begin
            state_d[g] = StIdle;
          end
        end
        StLock: begin
          if (!entry[g]) begin
            state_d[g] = StIdle;
            tries_d[g] = '0;
          end
        end
        default: state_d[g] = StIdle;
      endcase
    end
  end

  always_comb begin
    occ_sum = int'(occ_q) + int'(grant[0]) + int'(grant[1])
            - int'(exit_rise[0]) - int'(exit_rise[1]);
    if (occ_sum < 0) begin
      occ_d = '0;
    end else if (occ_sum > int'(Capacity)) begin
      occ_d = 4'(Capacity);
    end else begin
      occ_d = 4'(occ_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= StIdle;
        timer_q[g] <= '0;
        tries_q[g] <= '0;
      end
      exit_q <= 2'b00;
      rr_q   <= 1'b0;
      occ_q  <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= state_d[g];
        timer_q[g] <= timer_d[g];
        tries_q[g] <= tries_d[g];
      end
      exit_q <= exit_lvl;
      rr_q   <= rr_d;
      occ_q  <= occ_d;
    end
  end

  assign bus.Greenled1 = (state_q[0] == StOpen);
  assign bus.Greenled2 = (state_q[1] == StOpen);
  assign bus.Redled1   = (state_q[0] == StLock) || (state_q[0] == StFull);
  assign bus.Redled2   = (state_q[1] == StLock) || (state_q[1] == StFull);
  assign bus.occupancy = occ_q;
  assign bus.full      = (occ_q == 4'(Capacity));

endmodule
